sim_ctrl: RTL and testbench
===========================

# sim_ctrl

Synthesizable simulation controller between the bench and the tinyriscv core. It sequences core reset for a parametrised number of cycles after bench reset. It then monitors data-memory writes for a tohost pass/fail code and enforces a cycle-count watchdog. It also logs writes to a signature address into a circular buffer, so benches and FPGA bring-up get a deterministic end-of-test verdict instead of a fixed wall-clock stop.

## Interface
- RST_CYCLES, 4: cycles core_rst_n is held low after rst deasserts; minimum 1.
- TIMEOUT, 1000: RUN-state cycle budget before verdict TIMEOUT; minimum 1.
- CNT_W, 32: width of the cycle and retire counters; 2^CNT_W > TIMEOUT.
- TOHOST_ADDR, 32'h0000_1000: word address watched for the verdict.
- SIG_ADDR, 32'h0000_1004: word address whose writes are logged.
- SIG_DEPTH, 8: signature buffer entries; power of two, ≥2.
- clk  in  1  single clock, rising edge.
- rst  in  1  one clock; reset is asynchronous and active-high.
- core_rst_n  out  1  reset to the core, active-low.
- mem_we  in  1  core data-memory write strobe.
- mem_addr  in  32  write address.
- mem_wdata  in  32  write data.
- inst_retire  in  1  one instruction retired this cycle.
- done  out  1  verdict valid; sticky until rst.
- result  out  2  00 none, 01 PASS, 10 FAIL, 11 TIMEOUT.
- fail_code  out  32  mem_wdata>>1 of a failing tohost write, else 0.
- cycles  out  CNT_W  RUN cycles elapsed.
- retired  out  CNT_W  instructions retired in RUN.
- sig_count  out  $clog2(SIG_DEPTH)+1  valid entries, saturating at SIG_DEPTH.
- sig_ovf  out  1  at least one entry overwritten.
- sig_raddr  in  $clog2(SIG_DEPTH)  read index, 0 = oldest valid entry.
- sig_rdata  out  32  combinational read of that entry.

## Operation
- FSM states: HOLD, RUN, DONE. rst forces HOLD immediately.
- All outputs are 0 on reset: core_rst_n, done, result, fail_code, cycles, retired, sig_count, sig_ovf. Buffer contents are unspecified; sig_rdata is don't-care while sig_count=0.
- HOLD: a hold counter increments each cycle. It moves to RUN on the edge where the counter reaches RST_CYCLES-1. core_rst_n is registered high on that same edge.
- RUN: cycles increments every cycle; retired increments when inst_retire=1.
- Write monitoring is active only when mem_we=1 and the state is RUN.
- Write to TOHOST_ADDR with wdata==0: ignored.
- Write to TOHOST_ADDR with wdata==1: go to DONE, result=01.
- Write to TOHOST_ADDR with any other wdata: go to DONE, result=10, fail_code=wdata>>1.
- Write to SIG_ADDR: wdata is stored at wr_ptr and wr_ptr is incremented modulo SIG_DEPTH. sig_count increments until it saturates. The first write while already full sets sig_ovf and overwrites the oldest entry.
- Timeout: in RUN with cycles==TIMEOUT-1 and no verdict write, go to DONE with result=11.
- Simultaneous tohost verdict write and timeout: the tohost verdict wins.
- DONE: done=1. result, fail_code, cycles, retired and the buffer are frozen, and all monitor inputs are ignored. core_rst_n stays 1. Only rst leaves DONE.
- Read mapping: sig_rdata = buf[(wr_ptr - sig_count + sig_raddr) mod SIG_DEPTH]. A sig_raddr ≥ sig_count returns don't-care.

## Timing
- After rst deasserts, core_rst_n rises after exactly RST_CYCLES rising edges.
- rst asserted mid-RUN or in DONE clears everything asynchronously, with no pending-write carry-over.
- Verdict latency: done, result and fail_code are registered on the same edge that samples the tohost write, so they are visible 1 cycle after the write.
- The final cycles value equals the number of RUN edges, counting the verdict edge. For a timeout, cycles==TIMEOUT.
- A signature write and a tohost write in the same cycle cannot occur, because the addresses differ; each is handled independently.
- The last cycle's inst_retire is counted on the verdict edge.
- Counters never wrap, because of the 2^CNT_W > TIMEOUT requirement.

## Test plan
- RST_CYCLES=4, rst released at edge 0 -> core_rst_n=0 through edge 3, 1 from edge 4; all outputs 0 before that.
- Write 0 then 1 to 0x1000 at RUN cycle 50 -> the 0 is ignored; done=1, result=01, fail_code=0, cycles=51, frozen thereafter.
- Write 0x0000_0007 to 0x1000 -> result=10, fail_code=3; later writes and inst_retire have no effect.
- TIMEOUT=20, no tohost write -> done at cycles=20, result=11. A variant with the tohost write of 1 at cycle 19 gives result=01.
- SIG_DEPTH=4, write 10,11,12,13,14,15 to 0x1004 -> sig_count=4, sig_ovf=1, sig_rdata for raddr 0..3 = 12,13,14,15. Writes to that address in HOLD are not logged.
- Assert rst for 1 ns mid-RUN between edges -> immediate return to HOLD, all outputs 0; a full re-sequence then gives a PASS on rerun.

Source files
------------

// File: rtl/sim_ctrl.sv
// Simulation controller: sequences core reset, watches tohost for a verdict,
// enforces a RUN-cycle watchdog and logs signature writes into a ring buffer.
module sim_ctrl #(
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned CNT_W       = 32,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter logic [31:0] SIG_ADDR    = 32'h0000_1004,
    parameter int unsigned SIG_DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       core_rst_n,
    input  logic                       mem_we,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic                       inst_retire,
    output logic                       done,
    output logic [1:0]                 result,
    output logic [31:0]                fail_code,
    output logic [CNT_W-1:0]           cycles,
    output logic [CNT_W-1:0]           retired,
    output logic [$clog2(SIG_DEPTH):0] sig_count,
    output logic                       sig_ovf,
    input  logic [$clog2(SIG_DEPTH)-1:0] sig_raddr,
    output logic [31:0]                sig_rdata
);

    localparam int unsigned PW = $clog2(SIG_DEPTH);
    localparam int unsigned HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [PW:0]      SIG_FULL  = (PW+1)'(SIG_DEPTH);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [HW-1:0]    r_hold_cnt;
    logic             r_core_rst_n;
    logic             r_done;
    logic [1:0]       r_result;
    logic [31:0]      r_fail_code;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] r_retired;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_sig_count;
    logic             r_sig_ovf;
    logic [31:0]      r_buf [SIG_DEPTH];

    logic          w_run;
    logic          w_tohost_wr;
    logic          w_sig_wr;
    logic          w_timeout;
    logic [PW-1:0] w_rd_idx;

    assign w_run       = (r_state == S_RUN);
    assign w_tohost_wr = w_run && mem_we && (mem_addr == TOHOST_ADDR) && (mem_wdata != '0);
    assign w_sig_wr    = w_run && mem_we && (mem_addr == SIG_ADDR);
    assign w_timeout   = w_run && (r_cycles == RUN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_HOLD;
            r_hold_cnt   <= '0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_result     <= 2'b00;
            r_fail_code  <= '0;
            r_cycles     <= '0;
            r_retired    <= '0;
            r_wr_ptr     <= '0;
            r_sig_count  <= '0;
            r_sig_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state      <= S_RUN;
                        r_core_rst_n <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                S_RUN: begin
                    r_cycles <= r_cycles + CNT_W'(1);
                    if (inst_retire)
                        r_retired <= r_retired + CNT_W'(1);
                    // A verdict write on the watchdog's last cycle takes precedence.
                    if (w_tohost_wr) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        if (mem_wdata == 32'd1) begin
                            r_result    <= 2'b01;
                            r_fail_code <= '0;
                        end else begin
                            r_result    <= 2'b10;
                            r_fail_code <= {1'b0, mem_wdata[31:1]};
                        end
                    end else if (w_timeout) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= 2'b11;
                    end
                    if (w_sig_wr) begin
                        r_wr_ptr <= r_wr_ptr + PW'(1);
                        if (r_sig_count == SIG_FULL)
                            r_sig_ovf <= 1'b1;
                        else
                            r_sig_count <= r_sig_count + (PW+1)'(1);
                    end
                end
                S_DONE: begin
                end
                default: r_state <= S_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_sig_wr)
            r_buf[r_wr_ptr] <= mem_wdata;
    end

    // Oldest valid entry sits sig_count slots behind the write pointer.
    assign w_rd_idx  = r_wr_ptr - r_sig_count[PW-1:0] + sig_raddr;
    assign sig_rdata = r_buf[w_rd_idx];

    assign core_rst_n = r_core_rst_n;
    assign done       = r_done;
    assign result     = r_result;
    assign fail_code  = r_fail_code;
    assign cycles     = r_cycles;
    assign retired    = r_retired;
    assign sig_count  = r_sig_count;
    assign sig_ovf    = r_sig_ovf;

endmodule

// File: tb/tb_sim_ctrl.sv
// Scoreboard bench for sim_ctrl: randomized and directed episodes, verdicts
// predicted by a list-based reference model and checked by a done monitor.
module tb_sim_ctrl;

    localparam int unsigned RST_CYCLES = 4;
    localparam int unsigned TIMEOUT    = 64;
    localparam int unsigned SIG_DEPTH  = 4;
    localparam logic [31:0] TOHOST     = 32'h0000_1000;
    localparam logic [31:0] SIGA       = 32'h0000_1004;
    localparam int unsigned NEV        = TIMEOUT + 8;

    localparam int K_NONE = 0, K_TOHOST = 1, K_SIG = 2, K_OTHER = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_rst_n;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        inst_retire = 1'b0;
    logic        done;
    logic [1:0]  result;
    logic [31:0] fail_code;
    logic [31:0] cycles;
    logic [31:0] retired;
    logic [2:0]  sig_count;
    logic        sig_ovf;
    logic [1:0]  sig_raddr = '0;
    logic [31:0] sig_rdata;

    sim_ctrl #(
        .RST_CYCLES (RST_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (32),
        .TOHOST_ADDR(TOHOST),
        .SIG_ADDR   (SIGA),
        .SIG_DEPTH  (SIG_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_rst_n (core_rst_n),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .inst_retire(inst_retire),
        .done       (done),
        .result     (result),
        .fail_code  (fail_code),
        .cycles     (cycles),
        .retired    (retired),
        .sig_count  (sig_count),
        .sig_ovf    (sig_ovf),
        .sig_raddr  (sig_raddr),
        .sig_rdata  (sig_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       result;
        logic [31:0]      fail_code;
        logic [31:0]      cycles;
        logic [31:0]      retired;
        logic [2:0]       sig_count;
        logic             sig_ovf;
        logic [3:0][31:0] sig;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int          ev_kind [NEV];
    logic [31:0] ev_data [NEV];
    logic        ev_ret  [NEV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_core_rst_n"}, 64'(core_rst_n), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_result"}, 64'(result), 0);
        chk({tag, "_fail_code"}, 64'(fail_code), 0);
        chk({tag, "_cycles"}, 64'(cycles), 0);
        chk({tag, "_retired"}, 64'(retired), 0);
        chk({tag, "_sig_count"}, 64'(sig_count), 0);
        chk({tag, "_sig_ovf"}, 64'(sig_ovf), 0);
    endtask

    function automatic void clear_events();
        for (int k = 0; k < int'(NEV); k++) begin
            ev_kind[k] = K_NONE;
            ev_data[k] = '0;
            ev_ret[k]  = 1'($urandom_range(0, 1));
        end
    endfunction

    // Reference model: walk RUN cycles in order, collect logged signature
    // values in a list, stop at the first nonzero tohost value or the budget.
    function automatic void model(output exp_t e, output int vk);
        logic [31:0] logq[$];
        int n;
        e  = '0;
        vk = -1;
        for (int k = 0; k < int'(NEV); k++) begin
            if (ev_ret[k]) e.retired++;
            if (ev_kind[k] == K_SIG) logq.push_back(ev_data[k]);
            if (ev_kind[k] == K_TOHOST && ev_data[k] != 0) begin
                e.result    = (ev_data[k] == 1) ? 2'b01 : 2'b10;
                e.fail_code = (ev_data[k] == 1) ? 32'd0 : ev_data[k] / 2;
                e.cycles    = k + 1;
                vk = k;
                break;
            end
            if (k == int'(TIMEOUT) - 1) begin
                e.result = 2'b11;
                e.cycles = TIMEOUT;
                vk = k;
                break;
            end
        end
        n = (logq.size() > int'(SIG_DEPTH)) ? int'(SIG_DEPTH) : logq.size();
        e.sig_count = 3'(n);
        e.sig_ovf   = logq.size() > int'(SIG_DEPTH);
        for (int i = 0; i < n; i++)
            e.sig[i] = logq[logq.size() - n + i];
    endfunction

    task automatic drive_event(input int k);
        inst_retire = ev_ret[k];
        mem_wdata   = ev_data[k];
        case (ev_kind[k])
            K_TOHOST: begin mem_we = 1'b1; mem_addr = TOHOST; end
            K_SIG:    begin mem_we = 1'b1; mem_addr = SIGA; end
            K_OTHER:  begin mem_we = 1'b1; mem_addr = 32'h2000 + 32'($urandom_range(0, 255)) * 4; end
            default:  begin mem_we = 1'b0; mem_addr = '0; end
        endcase
    endtask

    // with_reset=0 means the previous episode already left rst just released.
    task automatic run_episode(input int abort_at, input bit with_reset);
        exp_t e;
        int   vk;
        model(e, vk);
        if (abort_at < 0) sb.push_back(e);
        if (with_reset) begin
            rst = 1'b1;
            mem_we = 1'b0;
            #1;
            check_zero("rst");
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        for (int h = 0; h < int'(RST_CYCLES); h++) begin
            // Writes during HOLD must not be logged or produce a verdict.
            mem_we      = 1'b1;
            mem_addr    = (h % 2 == 0) ? SIGA : TOHOST;
            mem_wdata   = (h % 2 == 0) ? 32'hDEAD_0000 + 32'(h) : 32'd1;
            inst_retire = 1'b1;
            @(posedge clk);
            #1;
            chk("core_rst_n_seq", 64'(core_rst_n), 64'(h == int'(RST_CYCLES) - 1));
        end
        chk("hold_sig_count", 64'(sig_count), 0);
        chk("hold_retired", 64'(retired), 0);
        for (int k = 0; k < int'(NEV); k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check_zero("abort");
                rst = 1'b0;
                return;
            end
            drive_event(k);
            @(posedge clk);
            #1;
            chk("done_timing", 64'(done), 64'(vk >= 0 && k >= vk));
        end
        mem_we = 1'b0;
        inst_retire = 1'b0;
        chk("frz_result", 64'(result), 64'(e.result));
        chk("frz_fail_code", 64'(fail_code), 64'(e.fail_code));
        chk("frz_cycles", 64'(cycles), 64'(e.cycles));
        chk("frz_retired", 64'(retired), 64'(e.retired));
        chk("frz_sig_count", 64'(sig_count), 64'(e.sig_count));
        chk("frz_core_rst_n", 64'(core_rst_n), 1);
        chk("verdict_seen", 64'(sb.size()), 0);
        while (sb.size() > 0) void'(sb.pop_front());
    endtask

    // Monitor: each rising done is matched against the oldest expectation.
    initial begin
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no verdict at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'(result), 64'(e.result));
                    chk("fail_code", 64'(fail_code), 64'(e.fail_code));
                    chk("cycles", 64'(cycles), 64'(e.cycles));
                    chk("retired", 64'(retired), 64'(e.retired));
                    chk("sig_count", 64'(sig_count), 64'(e.sig_count));
                    chk("sig_ovf", 64'(sig_ovf), 64'(e.sig_ovf));
                    for (int i = 0; i < int'(e.sig_count); i++) begin
                        sig_raddr = 2'(i);
                        #1;
                        chk("sig_rdata", 64'(sig_rdata), 64'(e.sig[i]));
                    end
                end
            end
            prev = done;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        #1;
        check_zero("init");
        @(posedge clk);
        #1;

        // Pass after an ignored zero write.
        clear_events();
        ev_kind[40] = K_TOHOST; ev_data[40] = 32'd0;
        ev_kind[50] = K_TOHOST; ev_data[50] = 32'd1;
        ev_kind[5]  = K_SIG;    ev_data[5]  = 32'hA5;
        ev_kind[55] = K_SIG;    ev_data[55] = 32'hBAD;
        run_episode(-1, 1'b1);

        // Fail code 7 -> 3, with later writes ignored.
        clear_events();
        ev_kind[30] = K_TOHOST; ev_data[30] = 32'd7;
        ev_kind[31] = K_TOHOST; ev_data[31] = 32'd1;
        for (int k = 32; k < 40; k++) begin
            ev_kind[k] = K_SIG; ev_data[k] = 32'(k);
            ev_ret[k] = 1'b1;
        end
        run_episode(-1, 1'b1);

        // Pure timeout, then verdict on the watchdog's final cycle.
        clear_events();
        ev_kind[TIMEOUT-1] = K_SIG; ev_data[TIMEOUT-1] = 32'h77;
        run_episode(-1, 1'b1);
        clear_events();
        ev_kind[TIMEOUT-1] = K_TOHOST; ev_data[TIMEOUT-1] = 32'd1;
        run_episode(-1, 1'b1);

        // Signature overflow: 10..15 into a 4-entry buffer.
        clear_events();
        for (int i = 0; i < 6; i++) begin
            ev_kind[2+i] = K_SIG; ev_data[2+i] = 32'(10 + i);
        end
        ev_kind[20] = K_TOHOST; ev_data[20] = 32'd1;
        run_episode(-1, 1'b1);

        // Mid-RUN 1 ns reset, then a direct re-sequence to PASS.
        clear_events();
        ev_kind[3] = K_SIG; ev_data[3] = 32'h55;
        run_episode(10, 1'b1);
        clear_events();
        ev_kind[12] = K_SIG;    ev_data[12] = 32'h66;
        ev_kind[25] = K_TOHOST; ev_data[25] = 32'd1;
        run_episode(-1, 1'b0);

        // Randomized episodes.
        for (int ep = 0; ep < 10; ep++) begin
            clear_events();
            for (int k = 0; k < int'(NEV); k++) begin
                r = int'($urandom_range(0, 99));
                if (r < 2) begin
                    ev_kind[k] = K_TOHOST;
                    ev_data[k] = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
                end else if (r < 6) begin
                    ev_kind[k] = K_TOHOST; ev_data[k] = 32'd0;
                end else if (r < 30) begin
                    ev_kind[k] = K_SIG; ev_data[k] = $urandom;
                end else if (r < 40) begin
                    ev_kind[k] = K_OTHER; ev_data[k] = $urandom;
                end
            end
            run_episode(-1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
